ni_fifo_reader: RTL and testbench



---
 rtl/ni_pkg.sv | 14 +
 rtl/ni_flit_reg.sv | 62 ++++++
 rtl/ni_fifo_reader.sv | 127 ++++++++++++
 tb/tb_ni_fifo_reader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ni_pkg.sv
// Shared definitions for the network-interface FIFO read side: FSM state
// encoding, header length-field position and the default data width.
package ni_pkg;

   localparam int DEFAULT_DSIZE = 32;
   localparam int HDR_LEN_LSB   = 0;
   localparam int HDR_LEN_W     = 8;

   typedef enum logic {
      S_HEAD = 1'b0,
      S_BODY = 1'b1
   } state_e;

endpackage

// File: rtl/ni_flit_reg.sv
// Output flit register: loads on a pop, holds under backpressure and drops
// valid once the router has taken the flit and nothing new replaces it.
module ni_flit_reg
   import ni_pkg::*;
#(
   parameter int DSIZE = DEFAULT_DSIZE
) (
   input  logic             rclk,
   input  logic             rrst_n,
   input  logic             load,
   input  logic [DSIZE-1:0] load_data,
   input  logic             load_head,
   input  logic             load_tail,
   input  logic             flit_ready,
   output logic [DSIZE-1:0] flit_data,
   output logic             flit_head,
   output logic             flit_tail,
   output logic             flit_valid
);

   logic [DSIZE-1:0] data_q, data_d;
   logic             head_q, head_d;
   logic             tail_q, tail_d;
   logic             valid_q, valid_d;

   always_comb begin
      // NOTE: every _d gets its hold value first so no path through this block infers a latch.
      data_d  = data_q;
      head_d  = head_q;
      tail_d  = tail_q;
      valid_d = valid_q;
      if (load) begin
         data_d  = load_data;
         head_d  = load_head;
         tail_d  = load_tail;
         valid_d = 1'b1;
      end else if (flit_ready) begin
         valid_d = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         data_q  <= '0;
         head_q  <= 1'b0;
         tail_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         valid_q <= valid_d;
      end
   end

   assign flit_data  = data_q;
   assign flit_head  = head_q;
   assign flit_tail  = tail_q;
   assign flit_valid = valid_q;

endmodule

// File: rtl/ni_fifo_reader.sv
// Pops words from the async FIFO read port and frames them into head/body/tail
// flits. Define NI_RD_STATS_EN to add pkt_count/word_count statistics outputs.
module ni_fifo_reader
   import ni_pkg::*;
#(
   parameter int DSIZE   = DEFAULT_DSIZE,
   parameter int LEN_W   = HDR_LEN_W,
   parameter int MAX_LEN = 16
) (
   input  logic             rclk,
   input  logic             rrst_n,
   input  logic [DSIZE-1:0] fifo_rdata,
   input  logic             fifo_rempty,
   output logic             fifo_rinc,
   output logic [DSIZE-1:0] flit_data,
   output logic             flit_head,
   output logic             flit_tail,
   output logic             flit_valid,
   input  logic             flit_ready,
   output logic             pkt_busy,
   output logic             err_len
`ifdef NI_RD_STATS_EN
   ,
   output logic [15:0]      pkt_count,
   output logic [15:0]      word_count
`endif
);

   localparam int REM_W = $clog2(MAX_LEN + 1);

   state_e           state_q, state_d;
   logic [REM_W-1:0] remaining_q, remaining_d;
   logic             err_len_q, err_len_d;
   logic             head_d, tail_d;
   logic             pop;
   logic [LEN_W-1:0] hdr_len;
   logic             len_over;

   assign pop       = !fifo_rempty && (!flit_valid || flit_ready);
   assign fifo_rinc = pop;
   assign hdr_len   = fifo_rdata[HDR_LEN_LSB +: LEN_W];
   // Compared at full width so an oversize length can never alias below MAX_LEN.
   assign len_over  = 32'(hdr_len) > 32'(MAX_LEN);

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      err_len_d   = 1'b0;
      head_d      = 1'b0;
      tail_d      = 1'b0;
      if (pop) begin
         case (state_q)
            S_HEAD: begin
               head_d = 1'b1;
               if (hdr_len == '0) begin
                  tail_d = 1'b1;
               end else begin
                  remaining_d = len_over ? REM_W'(MAX_LEN) : REM_W'(hdr_len);
                  err_len_d   = len_over;
                  state_d     = S_BODY;
               end
            end
            S_BODY: begin
               tail_d      = (remaining_q == REM_W'(1));
               remaining_d = remaining_q - REM_W'(1);
               if (tail_d) state_d = S_HEAD;
            end
            default: state_d = S_HEAD;
         endcase
      end
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state_q     <= S_HEAD;
         remaining_q <= '0;
         err_len_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         err_len_q   <= err_len_d;
      end
   end

   assign pkt_busy = (state_q == S_BODY);
   assign err_len  = err_len_q;

   ni_flit_reg #(.DSIZE(DSIZE)) u_flit_reg (
      .rclk       (rclk),
      .rrst_n     (rrst_n),
      .load       (pop),
      .load_data  (fifo_rdata),
      .load_head  (head_d),
      .load_tail  (tail_d),
      .flit_ready (flit_ready),
      .flit_data  (flit_data),
      .flit_head  (flit_head),
      .flit_tail  (flit_tail),
      .flit_valid (flit_valid)
   );

`ifdef NI_RD_STATS_EN
   logic [15:0] pkt_count_q, pkt_count_d;
   logic [15:0] word_count_q, word_count_d;

   always_comb begin
      pkt_count_d  = pkt_count_q;
      word_count_d = word_count_q;
      if (flit_valid && flit_ready && flit_tail) pkt_count_d = pkt_count_q + 16'd1;
      if (pop) word_count_d = word_count_q + 16'd1;
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         pkt_count_q  <= '0;
         word_count_q <= '0;
      end else begin
         pkt_count_q  <= pkt_count_d;
         word_count_q <= word_count_d;
      end
   end

   assign pkt_count  = pkt_count_q;
   assign word_count = word_count_q;
`endif

endmodule

// File: tb/tb_ni_fifo_reader.sv
// Directed bench for ni_fifo_reader with a queue-based FIFO model; statistics
// checks are compiled in when NI_RD_STATS_EN is defined.
module tb_ni_fifo_reader;

   logic        rclk = 1'b0;
   logic        rrst_n;
   logic [31:0] fifo_rdata;
   logic        fifo_rempty;
   logic        fifo_rinc;
   logic [31:0] flit_data;
   logic        flit_head;
   logic        flit_tail;
   logic        flit_valid;
   logic        flit_ready;
   logic        pkt_busy;
   logic        err_len;
`ifdef NI_RD_STATS_EN
   logic [15:0] pkt_count;
   logic [15:0] word_count;
`endif

   logic [31:0] fifo_q[$];
   logic        pop_now;
   int          checks = 0;
   int          errors = 0;

   always #5 rclk = ~rclk;

   ni_fifo_reader #(.DSIZE(32), .LEN_W(8), .MAX_LEN(16)) dut (
      .rclk        (rclk),
      .rrst_n      (rrst_n),
      .fifo_rdata  (fifo_rdata),
      .fifo_rempty (fifo_rempty),
      .fifo_rinc   (fifo_rinc),
      .flit_data   (flit_data),
      .flit_head   (flit_head),
      .flit_tail   (flit_tail),
      .flit_valid  (flit_valid),
      .flit_ready  (flit_ready),
      .pkt_busy    (pkt_busy),
      .err_len     (err_len)
`ifdef NI_RD_STATS_EN
      ,
      .pkt_count   (pkt_count),
      .word_count  (word_count)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present the queue head to the DUT as the FIFO read port.
   task automatic refresh();
      fifo_rempty = (fifo_q.size() == 0);
      fifo_rdata  = (fifo_q.size() == 0) ? 32'h0 : fifo_q[0];
   endtask

   // Decide the pop before the edge, clock once, then retire the popped word.
   task automatic tick();
      refresh();
      #1;
      pop_now = fifo_rinc;
      @(posedge rclk);
      if (pop_now) void'(fifo_q.pop_front());
      #1;
      refresh();
      #1;
   endtask

   task automatic check_flit(input string tag, input logic [31:0] data,
                             input logic head, input logic tail);
      check({tag, "_valid"}, {31'b0, flit_valid}, 32'd1);
      check({tag, "_data"},  flit_data, data);
      check({tag, "_head"},  {31'b0, flit_head}, {31'b0, head});
      check({tag, "_tail"},  {31'b0, flit_tail}, {31'b0, tail});
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, {31'b0, flit_valid}, 32'd0);
      check({tag, "_head"},  {31'b0, flit_head}, 32'd0);
      check({tag, "_tail"},  {31'b0, flit_tail}, 32'd0);
      check({tag, "_data"},  flit_data, 32'd0);
      check({tag, "_err"},   {31'b0, err_len}, 32'd0);
      check({tag, "_busy"},  {31'b0, pkt_busy}, 32'd0);
      check({tag, "_rinc"},  {31'b0, fifo_rinc}, 32'd0);
   endtask

   initial begin
      rrst_n     = 1'b0;
      flit_ready = 1'b1;
      pop_now    = 1'b0;
      refresh();
      repeat (2) @(posedge rclk);
      #1;
      check_reset_outputs("reset");
      #2 rrst_n = 1'b1;

      // Two-payload packet streamed back-to-back.
      fifo_q.push_back(32'h0000_0002);
      fifo_q.push_back(32'h0000_BBBB);
      fifo_q.push_back(32'h0001_0001);
      refresh();
      #1;
      check("t1_rinc_first", {31'b0, fifo_rinc}, 32'd1);
      tick();
      check_flit("t1_f0", 32'h0000_0002, 1'b1, 1'b0);
      check("t1_busy0", {31'b0, pkt_busy}, 32'd1);
      tick();
      check_flit("t1_f1", 32'h0000_BBBB, 1'b0, 1'b0);
      check("t1_busy1", {31'b0, pkt_busy}, 32'd1);
      tick();
      check_flit("t1_f2", 32'h0001_0001, 1'b0, 1'b1);
      check("t1_busy2", {31'b0, pkt_busy}, 32'd0);
      tick();
      check("t1_drain", {31'b0, flit_valid}, 32'd0);

      // Zero-length header: single head+tail flit, no state change.
      fifo_q.push_back(32'h0100_CC00);
      tick();
      check_flit("t2", 32'h0100_CC00, 1'b1, 1'b1);
      check("t2_busy", {31'b0, pkt_busy}, 32'd0);
      check("t2_err", {31'b0, err_len}, 32'd0);
      tick();
      check("t2_drain", {31'b0, flit_valid}, 32'd0);

      // Backpressure after the header flit.
      fifo_q.push_back(32'h0000_0002);
      fifo_q.push_back(32'h0000_00A1);
      fifo_q.push_back(32'h0000_00A2);
      tick();
      check_flit("t3_hdr", 32'h0000_0002, 1'b1, 1'b0);
      flit_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("t3_rinc_held", {31'b0, fifo_rinc}, 32'd0);
         tick();
         check_flit("t3_held", 32'h0000_0002, 1'b1, 1'b0);
      end
      check("t3_qsize_held", fifo_q.size(), 32'd2);
      flit_ready = 1'b1;
      tick();
      check_flit("t3_b0", 32'h0000_00A1, 1'b0, 1'b0);
      tick();
      check_flit("t3_b1", 32'h0000_00A2, 1'b0, 1'b1);
      tick();
      check("t3_drain", {31'b0, flit_valid}, 32'd0);

      // Oversize length clamps to 16 payload words and flags err_len once.
      fifo_q.push_back(32'h0000_00FF);
      for (int i = 0; i < 16; i++) fifo_q.push_back(32'h0000_0100 + i);
      fifo_q.push_back(32'h0000_0000);
      tick();
      check_flit("t4_hdr", 32'h0000_00FF, 1'b1, 1'b0);
      check("t4_err_pulse", {31'b0, err_len}, 32'd1);
      for (int i = 0; i < 16; i++) begin
         tick();
         check_flit("t4_body", 32'h0000_0100 + i, 1'b0, (i == 15));
         check("t4_err_low", {31'b0, err_len}, 32'd0);
      end
      check("t4_busy_end", {31'b0, pkt_busy}, 32'd0);
      tick();
      check_flit("t4_next_hdr", 32'h0000_0000, 1'b1, 1'b1);
      tick();

      // Asynchronous reset in the middle of a len=4 packet.
      fifo_q.push_back(32'h0000_0004);
      fifo_q.push_back(32'h0000_00D1);
      fifo_q.push_back(32'h0000_00D2);
      fifo_q.push_back(32'h0000_00D3);
      tick();
      tick();
      check_flit("t5_pre", 32'h0000_00D1, 1'b0, 1'b0);
      check("t5_busy_pre", {31'b0, pkt_busy}, 32'd1);
      #1 rrst_n = 1'b0;
      fifo_q.delete();
      refresh();
      #1;
      check_reset_outputs("t5_async");
      tick();
      #2 rrst_n = 1'b1;
      fifo_q.push_back(32'h0000_0001);
      tick();
      check_flit("t5_hdr", 32'h0000_0001, 1'b1, 1'b0);
      check("t5_busy", {31'b0, pkt_busy}, 32'd1);
      fifo_q.push_back(32'h0000_00E0);
      tick();
      check_flit("t5_tail", 32'h0000_00E0, 1'b0, 1'b1);
      tick();
      check("t5_drain", {31'b0, flit_valid}, 32'd0);

`ifdef NI_RD_STATS_EN
      // Packets of length 0, 2 and 1 after a fresh reset.
      #1 rrst_n = 1'b0;
      #1;
      check("t6_pkt_rst", {16'b0, pkt_count}, 32'd0);
      check("t6_word_rst", {16'b0, word_count}, 32'd0);
      #1 rrst_n = 1'b1;
      fifo_q.push_back(32'h0000_0000);
      fifo_q.push_back(32'h0000_0002);
      fifo_q.push_back(32'h0000_0011);
      fifo_q.push_back(32'h0000_0012);
      fifo_q.push_back(32'h0000_0001);
      fifo_q.push_back(32'h0000_0021);
      repeat (7) tick();
      check("t6_pkt_count", {16'b0, pkt_count}, 32'd3);
      check("t6_word_count", {16'b0, word_count}, 32'd6);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Cycle budget so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
